// File: rtl/tlb_search_resp.sv
// Data-side TLB search responder: entry array, 3-state search handshake,
// entry write port and INVTLB invalidation.
package tlb_search_pkg;
  typedef struct packed {
    logic [18:0] vppn;
    logic        va12;
    logic [9:0]  asid;
  } tlb_s_req_t;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic [19:0] ppn0;
    logic [19:0] ppn1;
    logic [1:0]  plv0;
    logic [1:0]  plv1;
    logic [1:0]  mat0;
    logic [1:0]  mat1;
    logic        d0;
    logic        d1;
    logic        v0;
    logic        v1;
  } tlb_entry_t;

  localparam logic [5:0] PS_HUGE = 6'd21;

  // Tag compare; huge pages ignore the low 9 bits of the VPPN.
  function automatic logic vppn_match(input tlb_entry_t ent, input logic [18:0] vppn);
    if (ent.ps == PS_HUGE) return ent.vppn[18:9] == vppn[18:9];
    return ent.vppn == vppn;
  endfunction
endpackage

module tlb_search_resp
  import tlb_search_pkg::*;
#(
  parameter int unsigned TLB_ENTRY_NUM = 16,
  parameter int unsigned IDX_W         = $clog2(TLB_ENTRY_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tlb_req_valid_i,
  input  tlb_s_req_t        tlb_req_i,
  output logic              tlb_req_ready_o,
  output logic [IDX_W+32:0] tlb_resp_o,
  input  logic              tlb_we_i,
  input  logic [IDX_W-1:0]  tlb_w_index_i,
  input  tlb_entry_t        tlb_w_entry_i,
  input  logic              invtlb_valid_i,
  input  logic [4:0]        invtlb_op_i,
  input  logic [9:0]        invtlb_asid_i,
  input  logic [18:0]       invtlb_vppn_i
);

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
    logic [19:0]      ppn;
    logic [5:0]       ps;
    logic [1:0]       plv;
    logic [1:0]       mat;
    logic             d;
    logic             v;
  } tlb_s_resp_t;

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_RESP} state_t;

  state_t                   r_state, w_state_nxt;
  tlb_s_req_t               r_req;
  tlb_s_resp_t              r_resp, w_resp;
  tlb_entry_t               r_tlb [TLB_ENTRY_NUM];
  logic [TLB_ENTRY_NUM-1:0] w_hit, w_inv;
  logic [IDX_W-1:0]         w_hit_idx;
  tlb_entry_t               w_sel;
  logic                     w_odd;
  logic                     w_req_load, w_resp_load;

  // Per-entry search and invalidate match vectors.
  always_comb begin
    w_hit = '0;
    w_inv = '0;
    for (int i = 0; i < int'(TLB_ENTRY_NUM); i++) begin
      w_hit[i] = r_tlb[i].e && (r_tlb[i].g || r_tlb[i].asid == r_req.asid)
                 && vppn_match(r_tlb[i], r_req.vppn);
      case (invtlb_op_i)
        5'd0, 5'd1: w_inv[i] = 1'b1;
        5'd2:       w_inv[i] = r_tlb[i].g;
        5'd3:       w_inv[i] = !r_tlb[i].g;
        5'd4:       w_inv[i] = !r_tlb[i].g && r_tlb[i].asid == invtlb_asid_i;
        5'd5:       w_inv[i] = !r_tlb[i].g && r_tlb[i].asid == invtlb_asid_i
                               && vppn_match(r_tlb[i], invtlb_vppn_i);
        5'd6:       w_inv[i] = (r_tlb[i].g || r_tlb[i].asid == invtlb_asid_i)
                               && vppn_match(r_tlb[i], invtlb_vppn_i);
        default:    w_inv[i] = 1'b0;
      endcase
    end
  end

  // Lowest-index priority encode and half-page field select.
  always_comb begin
    w_hit_idx = '0;
    for (int i = int'(TLB_ENTRY_NUM) - 1; i >= 0; i--) begin
      if (w_hit[i]) w_hit_idx = IDX_W'(i);
    end
    w_sel  = r_tlb[w_hit_idx];
    w_odd  = (w_sel.ps == PS_HUGE) ? r_req.vppn[8] : r_req.va12;
    w_resp = '0;
    if (|w_hit) begin
      w_resp.found = 1'b1;
      w_resp.index = w_hit_idx;
      w_resp.ps    = w_sel.ps;
      w_resp.ppn   = w_odd ? w_sel.ppn1 : w_sel.ppn0;
      w_resp.plv   = w_odd ? w_sel.plv1 : w_sel.plv0;
      w_resp.mat   = w_odd ? w_sel.mat1 : w_sel.mat0;
      w_resp.d     = w_odd ? w_sel.d1   : w_sel.d0;
      w_resp.v     = w_odd ? w_sel.v1   : w_sel.v0;
    end
  end

  // Entry array: the write wins its own index over a same-cycle invalidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(TLB_ENTRY_NUM); i++) r_tlb[i] <= '0;
    end else begin
      for (int i = 0; i < int'(TLB_ENTRY_NUM); i++) begin
        if (tlb_we_i && tlb_w_index_i == IDX_W'(i)) r_tlb[i] <= tlb_w_entry_i;
        else if (invtlb_valid_i && w_inv[i])        r_tlb[i].e <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_req_load      = 1'b0;
    w_resp_load     = 1'b0;
    tlb_req_ready_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tlb_req_valid_i) begin
          w_req_load  = 1'b1;
          w_state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        if (!tlb_req_valid_i)                  w_state_nxt = S_IDLE;
        else if (tlb_we_i || invtlb_valid_i)   w_state_nxt = S_CMP;
        else begin
          w_resp_load = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        tlb_req_ready_o = tlb_req_valid_i;
        w_state_nxt     = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req  <= '0;
      r_resp <= '0;
    end else begin
      if (w_req_load)  r_req  <= tlb_req_i;
      if (w_resp_load) r_resp <= w_resp;
    end
  end

  assign tlb_resp_o = r_resp;

endmodule

// File: tb/tb_tlb_search_resp.sv
// Directed self-checking bench for tlb_search_resp (16 entries).
module tb_tlb_search_resp;
  import tlb_search_pkg::*;

  typedef struct packed {
    logic        found;
    logic [3:0]  index;
    logic [19:0] ppn;
    logic [5:0]  ps;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  tlb_s_req_t  req = '0;
  logic        ready;
  logic [36:0] resp_raw;
  logic        we = 1'b0;
  logic [3:0]  w_index = '0;
  tlb_entry_t  w_entry = '0;
  logic        inv_valid = 1'b0;
  logic [4:0]  inv_op = '0;
  logic [9:0]  inv_asid = '0;
  logic [18:0] inv_vppn = '0;

  int checks = 0;
  int errors = 0;

  tlb_search_resp #(.TLB_ENTRY_NUM(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .tlb_req_valid_i(req_valid), .tlb_req_i(req),
    .tlb_req_ready_o(ready), .tlb_resp_o(resp_raw),
    .tlb_we_i(we), .tlb_w_index_i(w_index), .tlb_w_entry_i(w_entry),
    .invtlb_valid_i(inv_valid), .invtlb_op_i(inv_op),
    .invtlb_asid_i(inv_asid), .invtlb_vppn_i(inv_vppn)
  );

  always #5 clk = ~clk;

  function automatic tlb_entry_t mk_entry(
    input logic [18:0] vppn, input logic [5:0] ps, input logic g, input logic [9:0] asid,
    input logic [19:0] ppn0, input logic [19:0] ppn1, input logic [1:0] plv1,
    input logic [1:0] mat1, input logic d1, input logic v0, input logic v1);
    tlb_entry_t t;
    t = '0;
    t.e = 1'b1; t.vppn = vppn; t.ps = ps; t.g = g; t.asid = asid;
    t.ppn0 = ppn0; t.ppn1 = ppn1; t.plv1 = plv1; t.mat1 = mat1;
    t.d1 = d1; t.v0 = v0; t.v1 = v1;
    return t;
  endfunction

  function automatic resp_t mk_resp(input logic [3:0] idx, input logic [19:0] ppn,
    input logic [5:0] ps, input logic [1:0] plv, input logic [1:0] mat,
    input logic d, input logic v);
    resp_t r;
    r.found = 1'b1; r.index = idx; r.ppn = ppn; r.ps = ps;
    r.plv = plv; r.mat = mat; r.d = d; r.v = v;
    return r;
  endfunction

  task automatic do_write(input logic [3:0] idx, input tlb_entry_t ent);
    we = 1'b1; w_index = idx; w_entry = ent;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic do_inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn);
    inv_valid = 1'b1; inv_op = op; inv_asid = asid; inv_vppn = vppn;
    @(posedge clk); #1;
    inv_valid = 1'b0;
  endtask

  // Full handshake from IDLE; returns the response and cycles to ready.
  task automatic do_search(input logic [18:0] vppn, input logic va12, input logic [9:0] asid,
                           output resp_t r, output int cyc);
    req = '{vppn: vppn, va12: va12, asid: asid};
    req_valid = 1'b1;
    cyc = 0;
    while (cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) break;
    end
    r = resp_t'(resp_raw);
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++;
    if (resp_raw !== 37'h0) begin errors++; $display("FAIL reset_resp: got %h expected 0", resp_raw); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_search();
    resp_t r; int cyc;
    do_search(19'h12345, 1'b0, 10'd1, r, cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL first_latency: got %0d expected 2", cyc); end
    checks++;
    if (r !== resp_t'(0)) begin errors++; $display("FAIL first_miss: got %h expected 0", r); end
  endtask

  task automatic test_page_select();
    resp_t r, e; int cyc;
    do_write(4'd3, mk_entry(19'h12345, 6'd12, 1'b0, 10'd5, 20'hAAAAA, 20'hBBBBB,
                            2'd3, 2'd1, 1'b1, 1'b1, 1'b1));
    do_search(19'h12345, 1'b1, 10'd5, r, cyc);
    e = mk_resp(4'd3, 20'hBBBBB, 6'd12, 2'd3, 2'd1, 1'b1, 1'b1);
    checks++;
    if (cyc !== 2 || r !== e) begin errors++; $display("FAIL odd_page: got %h cyc %0d expected %h", r, cyc, e); end
    do_search(19'h12345, 1'b0, 10'd5, r, cyc);
    e = mk_resp(4'd3, 20'hAAAAA, 6'd12, 2'd0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (cyc !== 2 || r !== e) begin errors++; $display("FAIL even_page: got %h cyc %0d expected %h", r, cyc, e); end
    do_search(19'h12345, 1'b1, 10'd6, r, cyc);
    checks++;
    if (cyc !== 2 || r !== resp_t'(0)) begin errors++; $display("FAIL asid_miss: got %h cyc %0d expected 0", r, cyc); end
  endtask

  task automatic test_huge_priority();
    resp_t r, e; int cyc;
    do_write(4'd7, mk_entry(19'h12200, 6'd21, 1'b1, 10'd0, 20'h11111, 20'h22222,
                            2'd0, 2'd0, 1'b0, 1'b1, 1'b1));
    do_write(4'd2, mk_entry(19'h12200, 6'd12, 1'b0, 10'd5, 20'h33333, 20'h44444,
                            2'd0, 2'd0, 1'b0, 1'b1, 1'b1));
    do_search(19'h123FF, 1'b0, 10'd5, r, cyc);
    e = mk_resp(4'd7, 20'h22222, 6'd21, 2'd0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (cyc !== 2 || r !== e) begin errors++; $display("FAIL huge_odd: got %h cyc %0d expected %h", r, cyc, e); end
    do_search(19'h12200, 1'b0, 10'd5, r, cyc);
    e = mk_resp(4'd2, 20'h33333, 6'd12, 2'd0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (cyc !== 2 || r !== e) begin errors++; $display("FAIL lowest_index: got %h cyc %0d expected %h", r, cyc, e); end
    do_search(19'h12200, 1'b1, 10'd9, r, cyc);
    e = mk_resp(4'd7, 20'h11111, 6'd21, 2'd0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (cyc !== 2 || r !== e) begin errors++; $display("FAIL huge_global_even: got %h cyc %0d expected %h", r, cyc, e); end
  endtask

  task automatic test_invtlb();
    resp_t r, e; int cyc;
    do_inv(5'd7, 10'd5, 19'h12345);
    do_search(19'h12345, 1'b1, 10'd5, r, cyc);
    e = mk_resp(4'd3, 20'hBBBBB, 6'd12, 2'd3, 2'd1, 1'b1, 1'b1);
    checks++;
    if (cyc !== 2 || r !== e) begin errors++; $display("FAIL inv_op7: got %h cyc %0d expected %h", r, cyc, e); end
    do_inv(5'd5, 10'd5, 19'h12345);
    do_search(19'h12345, 1'b1, 10'd5, r, cyc);
    e = mk_resp(4'd7, 20'h22222, 6'd21, 2'd0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (cyc !== 2 || r !== e) begin errors++; $display("FAIL inv_op5_cleared: got %h cyc %0d expected %h", r, cyc, e); end
    do_search(19'h12200, 1'b0, 10'd5, r, cyc);
    e = mk_resp(4'd2, 20'h33333, 6'd12, 2'd0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (cyc !== 2 || r !== e) begin errors++; $display("FAIL inv_op5_kept: got %h cyc %0d expected %h", r, cyc, e); end
    do_inv(5'd2, 10'd0, 19'h0);
    do_search(19'h12345, 1'b1, 10'd5, r, cyc);
    checks++;
    if (cyc !== 2 || r !== resp_t'(0)) begin errors++; $display("FAIL inv_op2_global: got %h cyc %0d expected 0", r, cyc); end
    do_search(19'h12200, 1'b0, 10'd5, r, cyc);
    checks++;
    if (cyc !== 2 || r !== e) begin errors++; $display("FAIL inv_op2_kept: got %h cyc %0d expected %h", r, cyc, e); end
  endtask

  task automatic test_hazards();
    resp_t r, e, prev; int cyc; int seen;
    // Write lands in CMP: one extra cycle, response sees the new entry.
    req = '{vppn: 19'h0ABCD, va12: 1'b0, asid: 10'd1};
    req_valid = 1'b1;
    cyc = 0;
    while (cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        we = 1'b1; w_index = 4'd9;
        w_entry = mk_entry(19'h0ABCD, 6'd12, 1'b1, 10'd0, 20'h55555, 20'h0,
                           2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
      end else we = 1'b0;
      if (ready) break;
    end
    r = resp_t'(resp_raw);
    req_valid = 1'b0;
    @(posedge clk); #1;
    e = mk_resp(4'd9, 20'h55555, 6'd12, 2'd0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (cyc !== 3) begin errors++; $display("FAIL we_in_cmp_latency: got %0d expected 3", cyc); end
    checks++;
    if (r !== e) begin errors++; $display("FAIL we_in_cmp_resp: got %h expected %h", r, e); end
    // Valid dropped in CMP: no ready, response register untouched.
    prev = e;
    req = '{vppn: 19'h12200, va12: 1'b0, asid: 10'd5};
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL drop_no_ready: got %0d pulses expected 0", seen); end
    checks++;
    if (resp_t'(resp_raw) !== prev) begin errors++; $display("FAIL drop_resp_held: got %h expected %h", resp_raw, prev); end
    // Write and invalidate-all together: only the written index survives.
    we = 1'b1; w_index = 4'd4;
    w_entry = mk_entry(19'h00777, 6'd12, 1'b0, 10'd3, 20'h66666, 20'h0,
                       2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    inv_valid = 1'b1; inv_op = 5'd0;
    @(posedge clk); #1;
    we = 1'b0; inv_valid = 1'b0;
    do_search(19'h00777, 1'b0, 10'd3, r, cyc);
    e = mk_resp(4'd4, 20'h66666, 6'd12, 2'd0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (cyc !== 2 || r !== e) begin errors++; $display("FAIL we_inv_written: got %h cyc %0d expected %h", r, cyc, e); end
    do_search(19'h12200, 1'b0, 10'd5, r, cyc);
    checks++;
    if (cyc !== 2 || r !== resp_t'(0)) begin errors++; $display("FAIL we_inv_cleared2: got %h cyc %0d expected 0", r, cyc); end
    do_search(19'h0ABCD, 1'b0, 10'd1, r, cyc);
    checks++;
    if (cyc !== 2 || r !== resp_t'(0)) begin errors++; $display("FAIL we_inv_cleared9: got %h cyc %0d expected 0", r, cyc); end
  endtask

  task automatic test_reset_mid_search();
    resp_t r; int cyc;
    req = '{vppn: 19'h00777, va12: 1'b0, asid: 10'd3};
    req_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || resp_raw !== 37'h0) begin
      errors++; $display("FAIL mid_reset: got ready %b resp %h expected 0 0", ready, resp_raw);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_search(19'h00777, 1'b0, 10'd3, r, cyc);
    checks++;
    if (cyc !== 2 || r !== resp_t'(0)) begin errors++; $display("FAIL mid_reset_cleared: got %h cyc %0d expected 0", r, cyc); end
  endtask

  initial begin
    test_reset();
    test_reset_search();
    test_page_select();
    test_huge_priority();
    test_invtlb();
    test_hazards();
    test_reset_mid_search();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlb_search_resp.md
# tlb_search_resp

Responder side of the data-side TLB search handshake: holds the TLB entry array, accepts one search request at a time from the address-translation initiator, and returns a registered `tlb_s_resp_t` with a single-cycle ready pulse. It also owns the entry write port (TLBWR/TLBFILL) and the INVTLB invalidation port driven from the CSR/commit stage. It sits between the MMU translation front-end and the CSR/commit logic.

## Interface

**Parameters**
- `TLB_ENTRY_NUM`, default 16: number of entries, power of two.
- `IDX_W`, default `$clog2(TLB_ENTRY_NUM)`: index width.

**Ports** (`tlb_s_req_t` = {vppn[18:0] = va[31:13], va12, asid[9:0]}; `tlb_s_resp_t` = {found, index[IDX_W-1:0], ppn[19:0], ps[5:0], plv[1:0], mat[1:0], d, v}; `tlb_entry_t` = {e, vppn[18:0], ps[5:0], g, asid[9:0], ppn0/1[19:0], plv0/1[1:0], mat0/1[1:0], d0/1, v0/1})
- `clk` in 1: clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `tlb_req_valid_i` in 1: search request valid. Held high until ready.
- `tlb_req_i` in `tlb_s_req_t`: search request. Stable while valid.
- `tlb_req_ready_o` out 1: one-cycle pulse; the response is valid in this cycle.
- `tlb_resp_o` out `tlb_s_resp_t`: registered search result.
- `tlb_we_i` in 1: entry write strobe.
- `tlb_w_index_i` in IDX_W: write index.
- `tlb_w_entry_i` in `tlb_entry_t`: write data.
- `invtlb_valid_i` in 1: invalidate strobe.
- `invtlb_op_i` in 5: INVTLB op.
- `invtlb_asid_i` in 10: INVTLB ASID operand.
- `invtlb_vppn_i` in 19: INVTLB VA[31:13] operand.

## Operation

**FSM**: IDLE, CMP, RESP. Reset state is IDLE.
- **IDLE**: if `tlb_req_valid_i` is high, register `tlb_req_i` and go to CMP.
- **CMP**:
  - If valid is low, go to IDLE.
  - Else if `tlb_we_i` or `invtlb_valid_i` is high this cycle, stay in CMP and re-compare next cycle against the updated array.
  - Otherwise compare, encode, register the result into `tlb_resp_o`, and go to RESP.
- **RESP**: `tlb_req_ready_o = tlb_req_valid_i`. Go to IDLE unconditionally. A write in RESP does not change the result; the search is ordered before the write.

**Match for entry i**:
- Requires e && (g || asid == req.asid).
- If ps == 21: vppn[18:9] == req.vppn[18:9]. Otherwise: vppn == req.vppn.
- Multiple hits resolve to the lowest index.

**Response fields**:
- Odd-page select is req.vppn[8] if ps == 21, else req.va12.
- Hit: found = 1, index = hit index; ps, plus ppn/plv/mat/d/v from the selected half.
- Miss: every field is 0.

**Write**: on `tlb_we_i`, entry[`tlb_w_index_i`] <= `tlb_w_entry_i` at the clock edge.

**INVTLB** clears e at the edge for every entry matching the op:
- 0, 1: all entries.
- 2: g = 1.
- 3: g = 0.
- 4: g = 0 && asid match.
- 5: g = 0 && asid match && vppn match.
- 6: (g || asid match) && vppn match.
- Op greater than 6: no effect; the exception is raised upstream.
- vppn match follows the ps rule above.
- If write and invalidate occur in the same cycle, the write wins for its index and the invalidate applies to all other entries.

## Timing

- **Reset**: all entries have e = 0; `tlb_req_ready_o` = 0; `tlb_resp_o` = all zero; FSM = IDLE.
- **Latency**: valid rises at edge T (FSM in IDLE). CMP occupies cycle T+1. Ready is high and the response is valid in cycle T+2.
- **Throughput**: one search per 3 cycles. The next request is accepted in the cycle after RESP.
- Each write or invalidate that hits CMP adds one cycle.
- `tlb_resp_o` holds its value until the next CMP→RESP update.
- **Valid withdrawn** in CMP or RESP (initiator flush): no ready pulse, FSM returns to IDLE, and the response register is not updated in CMP.
- **Reset asserted mid-search**: immediate return to IDLE, ready low, all entries invalid.
- `tlb_req_ready_o` is never high outside RESP.

## Test plan

- **Reset then search**: reset, then search vppn=0x12345, asid=1 → ready in the 2nd cycle after acceptance, found = 0, all fields 0.
- **Even/odd page select**:
  - Setup: write idx 3 with {e=1, vppn=0x12345, ps=12, g=0, asid=5, ppn0=0xAAAAA, ppn1=0xBBBBB, v0=v1=1}.
  - Search asid=5, va12=1 → found = 1, index = 3, ppn = 0xBBBBB.
  - Search asid=6 → found = 0.
- **Huge page and priority**:
  - Setup: idx 7 has ps=21, g=1, vppn=0x12200. idx 2 has ps=12 and the same tag.
  - Search vppn=0x123FF with vppn[8]=1 → index 7, odd half.
  - Search vppn=0x12200 → index 2 (lowest index wins).
- **INVTLB ops**:
  - Op 5 with asid=5, vppn=0x12345 clears only the matching g = 0 entry.
  - Op 2 clears only global entries.
  - Op 7 changes nothing.
  - A subsequent search confirms each result.
- **Hazards**:
  - `tlb_we_i` in the CMP cycle writes the matching entry → ready is delayed by 1 cycle and the response reflects the new entry.
  - Valid dropped in CMP → no ready pulse, FSM in IDLE.
  - Write and invtlb op 0 in the same cycle → only the written index remains valid.
